// File: rtl/adder_pipe_arbiter.sv
// Four-way scheduler sharing a 2-stage nibble-split 8-bit adder, with flush FSM.
// Define ADDER_ARB_FIXED_PRI_EN for fixed priority (lowest index wins).
module adder_pipe_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                     enable,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [8*NREQ-1:0]        a_in,
  input  logic [8*NREQ-1:0]        b_in,
  input  logic [NREQ-1:0]          cin_in,
  output logic [NREQ-1:0]          gnt,
  output logic                     rsp_valid,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [7:0]               rsp_sum,
  output logic                     rsp_cout,
  input  logic                     flush_req,
  output logic                     flush_done
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALT
  } state_t;

  typedef struct packed {
    logic           valid;
    logic [IDW-1:0] id;
    logic [3:0]     low;
    logic           c4;
    logic [3:0]     a_hi;
    logic [3:0]     b_hi;
  } s1_t;

  state_t         state;
  state_t         state_next;
  logic           run_ok;
  logic           done_next;
  logic           hit;
  logic           issue;
  logic [IDW-1:0] pick;
  logic [7:0]     a_sel;
  logic [7:0]     b_sel;
  logic           cin_sel;
  logic [4:0]     lo_sum;
  logic [4:0]     hi_sum;
  s1_t            s1;

  always_ff @(posedge enable or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // The op held in the response register retires this cycle,
  // so only stage 1 can still be carrying work.
  always_comb begin
    state_next = state;
    unique case (state)
      RUN:     if (flush_req) state_next = DRAIN;
      DRAIN:   if (!s1.valid) state_next = HALT;
      HALT:    if (!flush_req) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    run_ok    = (state == RUN) && !flush_req && !rst;
    done_next = (state_next == HALT);
  end

  always_ff @(posedge enable or posedge rst) begin
    if (rst) flush_done <= 1'b0;
    else     flush_done <= done_next;
  end

`ifdef ADDER_ARB_FIXED_PRI_EN
  always_comb begin
    hit  = 1'b0;
    pick = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!hit && req[i]) begin
        hit  = 1'b1;
        pick = IDW'(i);
      end
    end
  end
`else
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] cand;

  // Search starts one past the last winner and wraps.
  always_comb begin
    hit  = 1'b0;
    pick = '0;
    cand = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = ptr + IDW'(k);
      if (!hit && req[cand]) begin
        hit  = 1'b1;
        pick = cand;
      end
    end
  end

  always_ff @(posedge enable or posedge rst) begin
    if (rst)        ptr <= IDW'(NREQ - 1);
    else if (issue) ptr <= pick;
  end
`endif

  assign issue = run_ok && hit;
  assign gnt   = issue ? (NREQ'(1) << pick) : '0;

  always_comb begin
    a_sel   = '0;
    b_sel   = '0;
    cin_sel = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == IDW'(i)) begin
        a_sel   = a_in[8*i +: 8];
        b_sel   = b_in[8*i +: 8];
        cin_sel = cin_in[i];
      end
    end
  end

  assign lo_sum = {1'b0, a_sel[3:0]}
                + {1'b0, b_sel[3:0]}
                + {4'b0, cin_sel};

  always_ff @(posedge enable or posedge rst) begin
    if (rst) begin
      s1 <= '0;
    end else begin
      s1.valid <= issue;
      if (issue) begin
        s1.id   <= pick;
        s1.low  <= lo_sum[3:0];
        s1.c4   <= lo_sum[4];
        s1.a_hi <= a_sel[7:4];
        s1.b_hi <= b_sel[7:4];
      end
    end
  end

  assign hi_sum = {1'b0, s1.a_hi}
                + {1'b0, s1.b_hi}
                + {4'b0, s1.c4};

  always_ff @(posedge enable or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_cout  <= 1'b0;
    end else begin
      rsp_valid <= s1.valid;
      if (s1.valid) begin
        rsp_id   <= s1.id;
        rsp_sum  <= {hi_sum[3:0], s1.low};
        rsp_cout <= hi_sum[4];
      end
    end
  end

endmodule

// File: tb/tb_adder_pipe_arbiter.sv
// Scoreboard bench for adder_pipe_arbiter; honours ADDER_ARB_FIXED_PRI_EN.
module tb_adder_pipe_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic [3:0]  cin_in;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_sum;
  logic        rsp_cout;
  logic        flush_req;
  logic        flush_done;

  adder_pipe_arbiter dut (
    .enable     (clk),
    .rst        (rst),
    .req        (req),
    .a_in       (a_in),
    .b_in       (b_in),
    .cin_in     (cin_in),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .flush_req  (flush_req),
    .flush_done (flush_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     id;
    int     sum9;
    longint due;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  longint     cyc = 0;
  logic [3:0] gseen = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Reference: spec-level arbitration, flush phases, result queue.
  int m_ptr = 3;
  int m_mode = 0;

  always @(negedge clk) begin
    logic [3:0] eg;
    int         pid;
    bit         empty;
    if (rst) begin
      m_ptr  = 3;
      m_mode = 0;
      sb.delete();
      chk("gnt_in_reset", gnt, 0);
      chk("flush_done_reset", flush_done, 0);
    end else begin
      eg  = '0;
      pid = -1;
      if (m_mode == 0 && !flush_req) begin
`ifdef ADDER_ARB_FIXED_PRI_EN
        for (int i = 0; i < 4; i++)
          if (pid < 0 && req[i]) pid = i;
`else
        for (int k = 1; k <= 4; k++)
          if (pid < 0 && req[(m_ptr + k) % 4]) pid = (m_ptr + k) % 4;
`endif
      end
      if (pid >= 0) begin
        eg[pid] = 1'b1;
        m_ptr   = pid;
        sb.push_back('{pid,
          int'(a_in[8*pid +: 8]) + int'(b_in[8*pid +: 8])
            + int'(cin_in[pid]), cyc + 2});
      end
      chk("gnt", gnt, eg);
      chk("flush_done", flush_done, (m_mode == 2) ? 1 : 0);
      empty = 1'b1;
      foreach (sb[j]) if (sb[j].due > cyc) empty = 1'b0;
      case (m_mode)
        0: if (flush_req) m_mode = 1;
        1: if (empty) m_mode = 2;
        default: if (!flush_req) m_mode = 0;
      endcase
    end
  end

  logic [7:0] last_sum = '0;
  logic [1:0] last_id = '0;
  logic       last_cout = 1'b0;

  // Monitor: pop and compare whenever the DUT presents a result.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("rsp_valid_reset", rsp_valid, 0);
      chk("rsp_sum_reset", rsp_sum, 0);
      chk("rsp_id_reset", rsp_id, 0);
      chk("rsp_cout_reset", rsp_cout, 0);
      last_sum  = '0;
      last_id   = '0;
      last_cout = 1'b0;
    end else if (rsp_valid) begin
      if (sb.size() == 0 || sb[0].due != cyc) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected: got id %0d sum %0h, none due (cycle %0d)",
                 rsp_id, rsp_sum, cyc);
      end else begin
        e = sb.pop_front();
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_sum", rsp_sum, e.sum9 & 255);
        chk("rsp_cout", rsp_cout, (e.sum9 >> 8) & 1);
      end
      last_sum  = rsp_sum;
      last_id   = rsp_id;
      last_cout = rsp_cout;
    end else begin
      chk("rsp_hold", {rsp_cout, rsp_id, rsp_sum},
          {last_cout, last_id, last_sum});
      if (sb.size() != 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        checks++;
        failures++;
        $display("FAIL rsp_missing: got no rsp_valid, required id %0d (cycle %0d)",
                 e.id, cyc);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    gseen = gnt;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rnd8();
    case ($urandom_range(3))
      0:       return 8'hFF;
      1:       return 8'h00;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic agents(input int density);
    for (int i = 0; i < 4; i++) begin
      if (!req[i] || gseen[i]) begin
        if ($urandom_range(99) < density) begin
          req[i]          = 1'b1;
          a_in[8*i +: 8]  = rnd8();
          b_in[8*i +: 8]  = rnd8();
          cin_in[i]       = 1'($urandom_range(1));
        end else begin
          req[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic one_op(input int id, input logic [7:0] a,
                        input logic [7:0] b, input logic c,
                        input logic [7:0] xs, input logic xc);
    int n;
    req            = '0;
    req[id]        = 1'b1;
    a_in[8*id +: 8] = a;
    b_in[8*id +: 8] = b;
    cin_in[id]     = c;
    tick();
    req = '0;
    n   = 0;
    while (n < 8) begin
      @(negedge clk);
      n++;
      if (rsp_valid) break;
    end
    chk("dir_latency", n, 2);
    chk("dir_id", rsp_id, id);
    chk("dir_sum", rsp_sum, xs);
    chk("dir_cout", rsp_cout, xc);
    @(posedge clk);
    #1;
  endtask

  function automatic int idx_of(input logic [3:0] g);
    for (int i = 0; i < 4; i++) if (g[i]) return i;
    return -1;
  endfunction

  initial begin
    int last;
    int want;
    rst       = 1'b1;
    req       = '0;
    a_in      = '0;
    b_in      = '0;
    cin_in    = '0;
    flush_req = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    one_op(0, 8'h3C, 8'h47, 1'b1, 8'h84, 1'b0);
    one_op(2, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    one_op(3, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    one_op(1, 8'h0F, 8'h00, 1'b1, 8'h10, 1'b0);

    // All four held continuously from reset.
    rst = 1'b1;
    req = 4'b1111;
    repeat (2) tick();
    rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      tick();
`ifdef ADDER_ARB_FIXED_PRI_EN
      chk("order", gseen, 4'b0001);
`else
      chk("order", gseen, 4'b0001 << (n % 4));
`endif
      agents(100);
    end

    // Directed flush with two ops in flight.
    repeat (3) begin tick(); agents(100); end
    last = idx_of(gseen);
    flush_req = 1'b1;
    @(negedge clk);
    chk("fl_gnt_F", gnt, 0);
    chk("fl_valid_F", rsp_valid, 1);
    @(negedge clk);
    chk("fl_valid_F1", rsp_valid, 1);
    chk("fl_done_F1", flush_done, 0);
    @(negedge clk);
    chk("fl_valid_F2", rsp_valid, 0);
    chk("fl_done_F2", flush_done, 1);
    @(posedge clk);
    #1;
    flush_req = 1'b0;
    tick();
    chk("fl_gnt_halt", gseen, 0);
    tick();
`ifdef ADDER_ARB_FIXED_PRI_EN
    want = 0;
`else
    want = (last + 1) % 4;
`endif
    chk("fl_resume", gseen, 4'b0001 << want);
    agents(100);

    // Reset with ops in flight.
    repeat (2) begin tick(); agents(100); end
    req = 4'b1111;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("rst_first_gnt", gseen, 4'b0001);
    chk("rst_no_valid", rsp_valid, 0);
    agents(100);

    // Randomised traffic with occasional flushes.
    for (int n = 0; n < 700; n++) begin
      tick();
      agents((n / 100) * 15 + 10);
      if ($urandom_range(99) < 4) flush_req = ~flush_req;
    end
    flush_req = 1'b0;
    req       = '0;
    repeat (6) tick();
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required end before time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adder_pipe_arbiter.md
# adder_pipe_arbiter

Round-robin scheduler that shares one 2-stage pipelined 8-bit adder among four requesters. It issues at most one operation per cycle, tags each operation with the requester ID through the pipeline, and returns sum, carry and tag two cycles after issue. A flush state machine stops issue and drains the pipeline on request. It sits between the requester clients and the adder datapath and contains its own copy of the nibble-split adder pipeline.

## Interface
- `NREQ`, 4: number of requesters (fixed at 4; ID width 2)
- `enable`  in  1  rising-edge clock
- `rst`  in  1  asynchronous reset, active-high
- `req`  in  4  per-requester operation request, level
- `a_in`  in  32  operand A, requester i on bits [8i+7:8i]
- `b_in`  in  32  operand B, same packing
- `cin_in`  in  4  carry-in, requester i on bit i
- `gnt`  out  4  one-hot grant, combinational; operation of granted requester is issued this cycle
- `rsp_valid`  out  1  result valid, registered
- `rsp_id`  out  2  requester ID of result
- `rsp_sum`  out  8  A+B+cin, low 8 bits
- `rsp_cout`  out  1  carry out of bit 7
- `flush_req`  in  1  level; request drain of pipeline
- `flush_done`  out  1  registered; pipeline empty and issue halted

## Operation
- Reset: `rsp_valid`, `rsp_id`, `rsp_sum`, `rsp_cout`, `flush_done` = 0; all pipeline valid bits 0; RR pointer = 3 (requester 0 highest priority first); state RUN. `gnt` = 0 while `rst` high.
- Arbitration (RUN only): search `req` starting at pointer+1 mod 4, wrapping; first set bit is granted. Pointer updates to granted index on the clock edge; unchanged if no grant.
- Requester holds `req` and operands until it sees `gnt`; `gnt` is the only accept.
- Stage 1 (issue edge): {c4, low[3:0]} = a[3:0]+b[3:0]+cin; register low, c4, a[7:4], b[7:4], ID, valid.
- Stage 2: {cout, high[3:0]} = a_hi+b_hi+c4; register {high,low}, cout, ID, valid to `rsp_*`.
- All arithmetic unsigned modulo 2^8; 255+255+1 gives sum 255, cout 1.
- `rsp_sum`/`rsp_cout`/`rsp_id` hold last value when `rsp_valid` = 0.
- No response backpressure: consumers accept every `rsp_valid` cycle.
- FSM: RUN -> DRAIN when `flush_req` = 1 (no grant in the cycle `flush_req` is first seen). DRAIN: `gnt` = 0; -> HALT when stage-1 and stage-2 valid both 0. HALT: `gnt` = 0, `flush_done` = 1; -> RUN when `flush_req` = 0. RR pointer preserved across flush.

## Timing
- Issue in cycle N (`gnt` high) -> `rsp_valid` high in cycle N+2. Latency 2, throughput 1 op/cycle.
- Back-to-back grants yield back-to-back results in grant order.
- Flush asserted in cycle F with ops issued in F-1 and F-2: results at F and F+1; state HALT and `flush_done` = 1 from F+2 at the earliest.
- `flush_req` dropped during DRAIN: DRAIN completes, HALT entered for one cycle, then RUN.
- `rst` mid-operation: in-flight ops discarded, no `rsp_valid` generated; outputs to reset values immediately.

## Configuration
- `ADDER_ARB_FIXED_PRI_EN` defined: fixed priority, lowest index wins; pointer logic removed.
- Undefined (default): round-robin as above.

## Test plan
- Single op: req=0001, a=0x3C, b=0x47, cin=1 -> gnt=0001 at N; cycle N+2 rsp_valid=1, id=0, sum=0x84, cout=0.
- Carry across nibble and out: a=0xFF, b=0x01, cin=0 on requester 2 -> sum=0x00, cout=1, id=2.
- All four req held continuously from reset -> grant order 0,1,2,3,0,…, one grant per cycle; results in the same order 2 cycles later (fixed-pri build: always 0).
- Flush: continuous req=1111, raise flush_req at cycle F -> gnt=0 from F; two results at F, F+1; flush_done=1 at F+2; drop flush_req -> grants resume at the requester after the last one granted.
- Reset mid-stream: assert rst with two ops in flight -> no rsp_valid afterwards; all outputs 0; first grant after release goes to requester 0.
